// File: rtl/decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : decode_ctrl_pipe
// Description : MIPS-I main decoder with registered valid/ready output
//               pipeline (1 or 2 stages), flush, CP0 exception code and
//               branch-delay-slot tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_ctrl_pipe #(
    parameter int unsigned DEPTH   = 1,     // 1 or 2 output stages (values above 2 behave as 2)
    parameter bit          EN_CP0  = 1'b1,  // decode MTC0/MFC0/ERET
    parameter bit          EN_HILO = 1'b1   // decode HI/LO, multiply and divide
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [13:0] out_ctrl,
    output logic [4:0]  out_exc,
    output logic        out_ds,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    // Control word bits, MSB first
    localparam logic [13:0] c_regwrite = 14'h2000;
    localparam logic [13:0] c_regdst   = 14'h1000;
    localparam logic [13:0] c_alusrc   = 14'h0800;
    localparam logic [13:0] c_branch   = 14'h0400;
    localparam logic [13:0] c_memtoreg = 14'h0200;
    localparam logic [13:0] c_memwrite = 14'h0100;
    localparam logic [13:0] c_jump     = 14'h0080;
    localparam logic [13:0] c_jal      = 14'h0040;
    localparam logic [13:0] c_jr       = 14'h0020;
    localparam logic [13:0] c_bal      = 14'h0010;
    localparam logic [13:0] c_hilo_en  = 14'h0008;
    localparam logic [13:0] c_mtc0_we  = 14'h0004;
    localparam logic [13:0] c_mfc0     = 14'h0002;
    localparam logic [13:0] c_eret     = 14'h0001;

    // Control transfers that make the following instruction a delay slot
    localparam logic [13:0] c_cti_mask = c_branch | c_jump | c_jal | c_jr;

    localparam logic [4:0]  c_exc_none = 5'h00;
    localparam logic [4:0]  c_exc_adel = 5'h04;
    localparam logic [4:0]  c_exc_sys  = 5'h08;
    localparam logic [4:0]  c_exc_bp   = 5'h09;
    localparam logic [4:0]  c_exc_ri   = 5'h0a;

    localparam logic [31:0] c_eret_word = 32'h42000018;

    // Payload layout: {ctrl[83:70], exc[69:65], ds[64], instr[63:32], pc[31:0]}
    localparam int c_pay_w = 84;

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [13:0] w_raw;
    logic        w_ri;
    logic        w_sys;
    logic        w_bp;
    logic [4:0]  w_exc;
    logic [13:0] w_ctrl;
    logic        w_is_cti;
    logic        w_accept;
    logic        w_ready0;
    logic        w_ready_last;
    logic        w_last_valid;
    logic [c_pay_w-1:0] w_last_pay;

    logic               r_valid0;
    logic [c_pay_w-1:0] r_pay0;
    logic               r_prev_br;

    assign w_op    = instr[31:26];
    assign w_funct = instr[5:0];
    assign w_rs    = instr[25:21];
    assign w_rt    = instr[20:16];

    // Main decode: raw control word plus reserved/syscall/break flags
    always_comb begin
        w_raw = '0;
        w_ri  = 1'b0;
        w_sys = 1'b0;
        w_bp  = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: w_raw = c_regwrite | c_regdst;
                    6'h08: w_raw = c_jr;
                    6'h09: w_raw = c_regwrite | c_regdst | c_jr;
                    6'h0c: w_sys = 1'b1;
                    6'h0d: w_bp  = 1'b1;
                    6'h10, 6'h12: begin
                        if (EN_HILO) w_raw = c_regwrite | c_regdst;
                        else         w_ri  = 1'b1;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: begin
                        if (EN_HILO) w_raw = c_hilo_en;
                        else         w_ri  = 1'b1;
                    end
                    default: w_ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (w_rt)
                    5'h00, 5'h01: w_raw = c_branch;
                    5'h10, 5'h11: w_raw = c_regwrite | c_branch | c_bal;
                    default:      w_ri  = 1'b1;
                endcase
            end
            6'h02: w_raw = c_jump;
            6'h03: w_raw = c_regwrite | c_jal;
            6'h04, 6'h05, 6'h06, 6'h07: w_raw = c_branch;
            6'h08, 6'h09, 6'h0a, 6'h0b,
            6'h0c, 6'h0d, 6'h0e, 6'h0f: w_raw = c_regwrite | c_alusrc;
            6'h10: begin
                if (!EN_CP0) begin
                    w_ri = 1'b1;
                end else if (instr == c_eret_word) begin
                    w_raw = c_eret;
                end else if (w_rs == 5'h04 && instr[10:3] == 8'h00) begin
                    w_raw = c_mtc0_we;
                end else if (w_rs == 5'h00 && instr[10:3] == 8'h00) begin
                    w_raw = c_regwrite | c_mfc0;
                end else begin
                    w_ri = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: w_raw = c_regwrite | c_alusrc | c_memtoreg;
            6'h28, 6'h29, 6'h2b:               w_raw = c_alusrc | c_memwrite;
            default: w_ri = 1'b1;
        endcase
    end

    // Exception priority AdEL > RI > Sys/Bp; any exception suppresses control
    always_comb begin
        w_exc = c_exc_none;
        if (pc[1:0] != 2'b00) w_exc = c_exc_adel;
        else if (w_ri)        w_exc = c_exc_ri;
        else if (w_sys)       w_exc = c_exc_sys;
        else if (w_bp)        w_exc = c_exc_bp;
        w_ctrl = (w_exc != c_exc_none) ? 14'h0000 : w_raw;
    end

    assign w_is_cti = |(w_ctrl & c_cti_mask);
    assign w_accept = in_valid & w_ready0 & ~flush;

    // Stage 0 register and delay-slot tracker, both advanced only on an accept
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_valid0  <= 1'b0;
            r_pay0    <= '0;
            r_prev_br <= 1'b0;
        end else if (flush) begin
            r_valid0  <= 1'b0;
            r_prev_br <= 1'b0;
        end else begin
            if (w_ready0) begin
                r_valid0 <= in_valid;
            end
            if (w_accept) begin
                r_pay0    <= {w_ctrl, w_exc, r_prev_br, instr, pc};
                r_prev_br <= w_is_cti;
            end
        end
    end

    generate
        if (DEPTH >= 2) begin : g_two_stage
            logic               r_valid1;
            logic [c_pay_w-1:0] r_pay1;

            // Stage 1 register fed from stage 0
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    r_valid1 <= 1'b0;
                    r_pay1   <= '0;
                end else if (flush) begin
                    r_valid1 <= 1'b0;
                end else if (w_ready_last) begin
                    r_valid1 <= r_valid0;
                    if (r_valid0) begin
                        r_pay1 <= r_pay0;
                    end
                end
            end

            assign w_last_valid = r_valid1;
            assign w_last_pay   = r_pay1;
            assign w_ready0     = ~r_valid0 | w_ready_last;
        end else begin : g_one_stage
            assign w_last_valid = r_valid0;
            assign w_last_pay   = r_pay0;
            assign w_ready0     = w_ready_last;
        end
    endgenerate

    // Ready chain depends only on stage valids and out_ready, never on in_valid
    assign w_ready_last = ~w_last_valid | out_ready;
    assign in_ready     = w_ready0;

    assign out_valid = w_last_valid;
    assign out_ctrl  = w_last_valid ? w_last_pay[83:70] : 14'h0000;
    assign out_exc   = w_last_valid ? w_last_pay[69:65] : 5'h00;
    assign out_ds    = w_last_pay[64];
    assign out_instr = w_last_pay[63:32];
    assign out_pc    = w_last_pay[31:0];

endmodule
`default_nettype wire

// File: tb/tb_decode_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_ctrl_pipe
// Description : Scoreboard bench for decode_ctrl_pipe. Instance 0 is DEPTH=2
//               with CP0 and HI/LO enabled, instance 1 is DEPTH=1 with both
//               feature groups disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_ctrl_pipe;

    typedef logic [83:0] item_t;

    logic        clk;
    logic        resetn;
    logic        in_valid_v  [2];
    logic        in_ready_v  [2];
    logic [31:0] instr_v     [2];
    logic [31:0] pc_v        [2];
    logic        flush_v     [2];
    logic        out_valid_v [2];
    logic        out_ready_v [2];
    logic [13:0] out_ctrl_v  [2];
    logic [4:0]  out_exc_v   [2];
    logic        out_ds_v    [2];
    logic [31:0] out_instr_v [2];
    logic [31:0] out_pc_v    [2];

    item_t q0[$];
    item_t q1[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    localparam logic [31:0] ORI    = 32'h34080005;
    localparam logic [31:0] LW     = 32'h8C090004;
    localparam logic [31:0] SW     = 32'hAC090008;
    localparam logic [31:0] BEQ    = 32'h11090003;
    localparam logic [31:0] ADDU   = 32'h01095021;
    localparam logic [31:0] RSVD   = 32'hFC000000;
    localparam logic [31:0] SYSC   = 32'h0000000C;
    localparam logic [31:0] BRK    = 32'h0000000D;
    localparam logic [31:0] MFC0   = 32'h40086000;
    localparam logic [31:0] MTC0   = 32'h40886000;
    localparam logic [31:0] ERET   = 32'h42000018;
    localparam logic [31:0] JAL    = 32'h0C000040;
    localparam logic [31:0] MULT   = 32'h01090018;
    localparam logic [31:0] BLTZAL = 32'h05100004;
    localparam logic [31:0] MFHI   = 32'h00004010;
    localparam logic [31:0] JR     = 32'h01000008;
    localparam logic [31:0] XORI   = 32'h39080001;

    decode_ctrl_pipe #(.DEPTH(2), .EN_CP0(1'b1), .EN_HILO(1'b1)) dut0 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .instr(instr_v[0]), .pc(pc_v[0]), .flush(flush_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .out_ctrl(out_ctrl_v[0]), .out_exc(out_exc_v[0]), .out_ds(out_ds_v[0]),
        .out_instr(out_instr_v[0]), .out_pc(out_pc_v[0])
    );

    decode_ctrl_pipe #(.DEPTH(1), .EN_CP0(1'b0), .EN_HILO(1'b0)) dut1 (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .instr(instr_v[1]), .pc(pc_v[1]), .flush(flush_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .out_ctrl(out_ctrl_v[1]), .out_exc(out_exc_v[1]), .out_ds(out_ds_v[1]),
        .out_instr(out_instr_v[1]), .out_pc(out_pc_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic report(input string nm, input logic [127:0] act,
                          input logic [127:0] exp, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        report(nm, act, exp, act === exp);
    endtask

    function automatic logic [127:0] outs_of(input int i);
        return {43'd0, out_valid_v[i], out_ctrl_v[i], out_exc_v[i], out_ds_v[i],
                out_instr_v[i], out_pc_v[i]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid_v[0] = 1'b0;
        in_valid_v[1] = 1'b0;
        repeat (n) step();
    endtask

    // Present one instruction and record its expected decode when accepted
    task automatic send(input int d, input logic [31:0] ins, input logic [31:0] p,
                        input logic [13:0] ctrl, input logic [4:0] exc, input logic ds);
        bit done = 1'b0;
        in_valid_v[d] = 1'b1;
        instr_v[d]    = ins;
        pc_v[d]       = p;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready_v[d] === 1'b1) begin
                if (d == 0) q0.push_back({ctrl, exc, ds, ins, p});
                else        q1.push_back({ctrl, exc, ds, ins, p});
                step();
                done = 1'b1;
            end
        end
        if (!done) begin
            report("send_timeout", 128'(ins), 128'(p), 1'b0);
            in_valid_v[d] = 1'b0;
        end
    endtask

    // Monitor: compare every completed output transfer with the scoreboard
    always @(negedge clk) begin : p_mon
        item_t e;
        item_t a;
        bit    have;
        if (mon_en) begin
            for (int i = 0; i < 2; i++) begin
                a = {out_ctrl_v[i], out_exc_v[i], out_ds_v[i], out_instr_v[i], out_pc_v[i]};
                if (out_valid_v[i] === 1'b1 && out_ready_v[i] === 1'b1) begin
                    have = 1'b0;
                    e    = '0;
                    if (i == 0 && q0.size() > 0) begin
                        e = q0.pop_front();
                        have = 1'b1;
                    end else if (i == 1 && q1.size() > 0) begin
                        e = q1.pop_front();
                        have = 1'b1;
                    end
                    if (!have) report("unexpected_out", 128'(a), 128'(0), 1'b0);
                    else       chk(i == 0 ? "out_item_d2" : "out_item_d1", 128'(a), 128'(e));
                end else if (out_valid_v[i] !== 1'b1) begin
                    chk("idle_zero", 128'({out_valid_v[i], out_ctrl_v[i], out_exc_v[i]}), 128'(0));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid_v[i]  = 1'b0;
            instr_v[i]     = '0;
            pc_v[i]        = '0;
            flush_v[i]     = 1'b0;
            out_ready_v[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_outputs", outs_of(i), 128'(0));
            chk("reset_in_ready", 128'(in_ready_v[i]), 128'(1'b1));
        end
        step();
        resetn = 1'b1;
        mon_en = 1'b1;

        // Latency of DEPTH=2: visible after the second edge
        send(0, ORI, 32'h100, 14'h2800, 5'h00, 1'b0);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("d2_latency_edge1", 128'(out_valid_v[0]), 128'(1'b0));
        step();
        @(negedge clk);
        chk("d2_latency_edge2", 128'(out_valid_v[0]), 128'(1'b1));
        step();

        send(0, LW,   32'h104, 14'h2A00, 5'h00, 1'b0);
        send(0, SW,   32'h108, 14'h0900, 5'h00, 1'b0);
        send(0, BEQ,  32'h10C, 14'h0400, 5'h00, 1'b0);
        send(0, ADDU, 32'h110, 14'h3000, 5'h00, 1'b1);
        send(0, ADDU, 32'h114, 14'h3000, 5'h00, 1'b0);
        send(0, BEQ,  32'h118, 14'h0400, 5'h00, 1'b0);
        idle(3);
        send(0, ADDU, 32'h11C, 14'h3000, 5'h00, 1'b1);
        send(0, RSVD, 32'h120, 14'h0000, 5'h0a, 1'b0);
        send(0, SYSC, 32'h124, 14'h0000, 5'h08, 1'b0);
        send(0, BRK,  32'h128, 14'h0000, 5'h09, 1'b0);
        send(0, RSVD, 32'hBFC00002, 14'h0000, 5'h04, 1'b0);
        send(0, MFC0, 32'h12C, 14'h2002, 5'h00, 1'b0);
        send(0, MTC0, 32'h130, 14'h0004, 5'h00, 1'b0);
        send(0, ERET, 32'h134, 14'h0001, 5'h00, 1'b0);
        send(0, JAL,  32'h138, 14'h2040, 5'h00, 1'b0);
        send(0, MULT, 32'h13C, 14'h0008, 5'h00, 1'b1);
        send(0, BLTZAL, 32'h140, 14'h2410, 5'h00, 1'b0);
        send(0, MFHI, 32'h144, 14'h3000, 5'h00, 1'b1);
        idle(3);

        // Backpressure on DEPTH=2: two accepts, then in_ready low and outputs frozen
        out_ready_v[0] = 1'b0;
        send(0, ORI, 32'h148, 14'h2800, 5'h00, 1'b0);
        send(0, LW,  32'h14C, 14'h2A00, 5'h00, 1'b0);
        in_valid_v[0] = 1'b1;
        instr_v[0]    = SW;
        pc_v[0]       = 32'h150;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 128'(in_ready_v[0]), 128'(1'b0));
            chk("bp_hold", outs_of(0),
                {43'd0, 1'b1, 14'h2800, 5'h00, 1'b0, ORI, 32'h148});
            step();
        end
        out_ready_v[0] = 1'b1;
        send(0, SW,   32'h150, 14'h0900, 5'h00, 1'b0);
        send(0, ADDU, 32'h154, 14'h3000, 5'h00, 1'b0);
        idle(3);

        // Flush with two in flight after a JR; the flush-cycle instruction is dropped
        send(0, JR,   32'h158, 14'h0020, 5'h00, 1'b0);
        send(0, ADDU, 32'h15C, 14'h3000, 5'h00, 1'b1);
        send(0, BEQ,  32'h160, 14'h0400, 5'h00, 1'b0);
        flush_v[0] = 1'b1;
        instr_v[0] = XORI;
        pc_v[0]    = 32'h164;
        step();
        flush_v[0]    = 1'b0;
        in_valid_v[0] = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("flush_out_valid", 128'(out_valid_v[0]), 128'(1'b0));
        step();
        @(negedge clk);
        chk("flush_no_accept", 128'(out_valid_v[0]), 128'(1'b0));
        step();
        send(0, ORI, 32'h200, 14'h2800, 5'h00, 1'b0);
        idle(3);

        // Mid-stream reset together with flush
        send(0, JR,   32'h204, 14'h0020, 5'h00, 1'b0);
        send(0, ADDU, 32'h208, 14'h3000, 5'h00, 1'b1);
        send(0, BEQ,  32'h20C, 14'h0400, 5'h00, 1'b0);
        resetn        = 1'b0;
        flush_v[0]    = 1'b1;
        in_valid_v[0] = 1'b0;
        step();
        q0.delete();
        q1.delete();
        @(negedge clk);
        chk("reset_mid_outputs", outs_of(0), 128'(0));
        chk("reset_mid_in_ready", 128'(in_ready_v[0]), 128'(1'b1));
        step();
        resetn     = 1'b1;
        flush_v[0] = 1'b0;
        send(0, ORI, 32'h210, 14'h2800, 5'h00, 1'b0);
        idle(3);

        // DEPTH=1 instance without CP0 and HI/LO
        send(1, ORI, 32'h300, 14'h2800, 5'h00, 1'b0);
        in_valid_v[1] = 1'b0;
        @(negedge clk);
        chk("d1_latency", 128'(out_valid_v[1]), 128'(1'b1));
        step();
        send(1, MFC0, 32'h304, 14'h0000, 5'h0a, 1'b0);
        send(1, MTC0, 32'h308, 14'h0000, 5'h0a, 1'b0);
        send(1, ERET, 32'h30C, 14'h0000, 5'h0a, 1'b0);
        send(1, MULT, 32'h310, 14'h0000, 5'h0a, 1'b0);
        send(1, MFHI, 32'h314, 14'h0000, 5'h0a, 1'b0);
        send(1, BEQ,  32'h318, 14'h0400, 5'h00, 1'b0);
        send(1, ADDU, 32'h31C, 14'h3000, 5'h00, 1'b1);
        idle(2);
        out_ready_v[1] = 1'b0;
        send(1, SW, 32'h320, 14'h0900, 5'h00, 1'b0);
        in_valid_v[1] = 1'b1;
        instr_v[1]    = LW;
        pc_v[1]       = 32'h324;
        @(negedge clk);
        chk("d1_bp_in_ready", 128'(in_ready_v[1]), 128'(1'b0));
        chk("d1_bp_hold", outs_of(1), {43'd0, 1'b1, 14'h0900, 5'h00, 1'b0, SW, 32'h320});
        step();
        out_ready_v[1] = 1'b1;
        send(1, LW, 32'h324, 14'h2A00, 5'h00, 1'b0);
        idle(3);

        for (int n = 0; n < 40 && (q0.size() != 0 || q1.size() != 0); n++) step();
        chk("drain_q0", 128'(q0.size()), 128'(0));
        chk("drain_q1", 128'(q1.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
